// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // One buffered fetch result: the word, the address it came from, and
    // whether it stands in for a misaligned redirect target.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_entry_t;

    // Clear the byte offset so the address points at a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle for fetch_unit: instruction-memory read port, redirect input
// and the decode-facing valid/ready output. The master side is the fetch
// unit; the slave side is the memory/decode environment.
// FETCH_ALIGN_CHECK_EN adds the instr_misaligned flag.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        instr_misaligned;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, instr_misaligned,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, instr_misaligned,
        output instr_ready
    );
`else
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and occupancy count.
// The head is read straight from storage, so a pushed entry appears one
// cycle later; an empty FIFO presents an all-zero head.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Pointer and occupancy next-state; flush empties the FIFO outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator. Issues sequential word reads to instruction
// memory under a credit rule that reserves a buffer slot for every
// outstanding request, buffers returned words with their PCs and hands
// them to decode. A redirect flushes the buffer and marks every request
// still in flight as stale so its response is dropped on return.
// Build option FETCH_ALIGN_CHECK_EN: a misaligned redirect target halts
// fetch and delivers a single NOP entry flagged as misaligned.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]     outst_q, outst_d;
    logic [OUT_W-1:0]     discard_q, discard_d;

    logic                 redirect;
    logic                 halt;
    logic                 can_issue;
    logic                 accept;
    logic                 resp_ok;
    logic                 resp_keep;
    logic                 head_valid;

    fetch_entry_t         buf_head, buf_push_data;
    logic                 buf_push, buf_pop;
    logic [BUF_CNT_W-1:0] buf_count;

    fetch_entry_t         pcq_head, pcq_push_data;
    logic [OUT_W-1:0]     pcq_count;

    assign redirect = bus.redirect_valid;

    // A request needs both a free outstanding slot and a guaranteed buffer
    // slot for its response; nothing issues in a redirect cycle or in reset.
    assign can_issue = rst_n && !redirect && !halt
                    && (int'(outst_q) < MAX_OUTSTANDING)
                    && ((int'(outst_q) + int'(buf_count)) < BUF_DEPTH);

    assign accept    = can_issue && bus.imem_gnt;
    assign resp_ok   = bus.imem_rvalid && (outst_q != '0);
    assign resp_keep = resp_ok && (discard_q == '0);

    assign bus.imem_req  = can_issue;
    assign bus.imem_addr = fetch_pc_q;

    assign head_valid      = (buf_count != '0);
    assign bus.instr_valid = head_valid;
    assign bus.instr       = buf_head.instr;
    assign bus.instr_pc    = buf_head.pc;

    assign buf_pop = head_valid && bus.instr_ready && !redirect;

    assign pcq_push_data = '{pc: fetch_pc_q, instr: '0, misaligned: 1'b0};

`ifdef FETCH_ALIGN_CHECK_EN
    logic        halt_q, halt_d;
    logic        mis_pend_q, mis_pend_d;
    logic [31:0] mis_pc_q, mis_pc_d;

    assign halt                 = halt_q;
    assign bus.instr_misaligned = buf_head.misaligned;

    // A misaligned target halts fetch and queues its NOP stand-in for the
    // following cycle, once the flush has emptied the buffer.
    always_comb begin
        halt_d     = halt_q;
        mis_pend_d = 1'b0;
        mis_pc_d   = mis_pc_q;
        if (redirect) begin
            halt_d     = (bus.redirect_pc[1:0] != 2'b00);
            mis_pend_d = (bus.redirect_pc[1:0] != 2'b00);
            mis_pc_d   = bus.redirect_pc;
        end
    end

    // Misaligned-redirect state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q     <= 1'b0;
            mis_pend_q <= 1'b0;
            mis_pc_q   <= '0;
        end else begin
            halt_q     <= halt_d;
            mis_pend_q <= mis_pend_d;
            mis_pc_q   <= mis_pc_d;
        end
    end
`else
    assign halt = 1'b0;
`endif

    // Buffer write: a live response paired with its queued PC, or the
    // misaligned stand-in entry when that option is built in.
    always_comb begin
        buf_push_data            = pcq_head;
        buf_push_data.instr      = bus.imem_rdata;
        buf_push_data.misaligned = 1'b0;
        buf_push                 = resp_keep && !redirect;
`ifdef FETCH_ALIGN_CHECK_EN
        if (mis_pend_q && !redirect) begin
            buf_push_data = '{pc: mis_pc_q, instr: NOP_INSTR, misaligned: 1'b1};
            buf_push      = 1'b1;
        end
`endif
    end

    // Fetch PC and in-flight bookkeeping; a redirect turns everything still
    // outstanding after this cycle into responses to be discarded.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            outst_d    = outst_d + OUT_W'(1);
        end
        if (resp_ok) begin
            outst_d = outst_d - OUT_W'(1);
            if (discard_q != '0) begin
                discard_d = discard_q - OUT_W'(1);
            end
        end
        if (redirect) begin
            fetch_pc_d = word_align(bus.redirect_pc);
            discard_d  = outst_d;
        end
    end

    // Fetch state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_ibuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (buf_push),
        .push_data_i (buf_push_data),
        .pop_i       (buf_pop),
        .flush_i     (redirect),
        .head_o      (buf_head),
        .count_o     (buf_count)
    );

    // In-order PCs of accepted requests; entries leave as responses return,
    // whether the response is kept or discarded.
    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_pcq (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept),
        .push_data_i (pcq_push_data),
        .pop_i       (resp_ok),
        .flush_i     (1'b0),
        .head_o      (pcq_head),
        .count_o     (pcq_count)
    );

    a_rvalid_with_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) bus.imem_rvalid |-> (outst_q != '0));

    a_pcq_tracks_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) pcq_count == outst_q);

`ifndef FETCH_ALIGN_CHECK_EN
    a_no_misaligned_entries: assert property (
        @(posedge clk) disable iff (!rst_n) !buf_head.misaligned);
`endif

endmodule
